// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer in front of a 4-byte-write data memory; sub-word stores use read-modify-write.
// Optional feature: define MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module mem_access_unit #(
    parameter int SIZE         = 32,
    parameter int DM_ADDR_BITS = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [SIZE-1:0] req_addr,
    input  logic [SIZE-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [SIZE-1:0] resp_rdata,
    output logic            resp_err,
    output logic [SIZE-1:0] dm_Address,
    output logic [SIZE-1:0] dm_WriteData,
    output logic            dm_MemRead,
    output logic            dm_MemWrite,
    input  logic [SIZE-1:0] dm_ReadData
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic [SIZE-1:0] resp_rdata_q, resp_rdata_d;
    logic [SIZE-1:0] dm_address_q, dm_address_d;
    logic [SIZE-1:0] dm_writedata_q, dm_writedata_d;
    logic            dm_memread_q, dm_memread_d;
    logic            dm_memwrite_q, dm_memwrite_d;

    logic            req_err;
    logic [SIZE-1:0] load_data;
    logic [SIZE-1:0] merge_data;

    // Any address bit above the memory's decode range is an out-of-range access.
    always_comb begin
        req_err = (req_size == 2'b11) || ((req_addr >> DM_ADDR_BITS) != '0);
`ifdef MISALIGN_TRAP_EN
        if ((req_size == 2'b01) && req_addr[0])
            req_err = 1'b1;
        if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
            req_err = 1'b1;
`endif
    end

    always_comb begin
        load_data  = dm_ReadData;
        merge_data = dm_ReadData;
        case (size_q)
            2'b00: begin
                load_data  = unsigned_q ? {{(SIZE-8){1'b0}}, dm_ReadData[7:0]}
                                        : {{(SIZE-8){dm_ReadData[7]}}, dm_ReadData[7:0]};
                merge_data = {dm_ReadData[SIZE-1:8], wdata_q[7:0]};
            end
            2'b01: begin
                load_data  = unsigned_q ? {{(SIZE-16){1'b0}}, dm_ReadData[15:0]}
                                        : {{(SIZE-16){dm_ReadData[15]}}, dm_ReadData[15:0]};
                merge_data = {dm_ReadData[SIZE-1:16], wdata_q};
            end
            default: begin
                load_data  = dm_ReadData;
                merge_data = dm_ReadData;
            end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        size_d         = size_q;
        unsigned_d     = unsigned_q;
        wdata_d        = wdata_q;
        resp_valid_d   = resp_valid_q;
        resp_err_d     = resp_err_q;
        resp_rdata_d   = resp_rdata_q;
        dm_address_d   = dm_address_q;
        dm_writedata_d = dm_writedata_q;
        dm_memread_d   = 1'b0;
        dm_memwrite_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d      = req_write;
                    size_d       = req_size;
                    unsigned_d   = req_unsigned;
                    wdata_d      = req_wdata[15:0];
                    dm_address_d = req_addr;
                    if (req_err) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (!req_write || (req_size != 2'b10)) begin
                        state_d      = ST_RD;
                        dm_memread_d = 1'b1;
                    end else begin
                        state_d        = ST_WR;
                        dm_writedata_d = req_wdata;
                        dm_memwrite_d  = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (!write_q) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = load_data;
                end else begin
                    state_d        = ST_WR;
                    dm_writedata_d = merge_data;
                    dm_memwrite_d  = 1'b1;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            default: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            write_q        <= 1'b0;
            size_q         <= 2'b00;
            unsigned_q     <= 1'b0;
            wdata_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_rdata_q   <= '0;
            dm_address_q   <= '0;
            dm_writedata_q <= '0;
            dm_memread_q   <= 1'b0;
            dm_memwrite_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            write_q        <= write_d;
            size_q         <= size_d;
            unsigned_q     <= unsigned_d;
            wdata_q        <= wdata_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            resp_rdata_q   <= resp_rdata_d;
            dm_address_q   <= dm_address_d;
            dm_writedata_q <= dm_writedata_d;
            dm_memread_q   <= dm_memread_d;
            dm_memwrite_q  <= dm_memwrite_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign resp_rdata   = resp_rdata_q;
    assign dm_Address   = dm_address_q;
    assign dm_WriteData = dm_writedata_q;
    assign dm_MemRead   = dm_memread_q;
    assign dm_MemWrite  = dm_memwrite_q;

endmodule
